regfile_wb_stage: RTL
=====================

Name: regfile_wb_stage

Overview:
- Operand-fetch and writeback stage wrapped around the two-stage ALU pipe.
- Holds a 2^AW x DW register file and drives abus/bbus combinationally from read addresses rs/rt.
- Carries destination address and write-enable through a delay line matched to ALU pipe latency (2 cycles), then writes the returned dbus into the register file.
- Flags read-after-write hazards that the delay line cannot resolve.

Parameters:
- DW, 32, data width of abus/bbus/dbus and of each register.
- AW, 5, register address width; file depth 2^AW.
- LAT, 2, ALU pipe latency in cycles (operand-capture edge to dbus valid); sets delay-line depth; legal values 1..4.

Ports:
- clk  in  1  rising-edge clock, shared with the ALU pipe.
- rst_n  in  1  asynchronous active-low reset.
- rs  in  AW  read address, port A.
- rt  in  AW  read address, port B.
- rd  in  AW  destination address of the op issued this cycle.
- wen  in  1  op issued this cycle writes a result.
- dbus  in  DW  result from the ALU pipe.
- abus  out  DW  operand A to the ALU pipe (combinational read).
- bbus  out  DW  operand B to the ALU pipe (combinational read).
- hazard  out  1  rs or rt matches an in-flight, not-yet-readable destination.
- wb_en  out  1  writeback occurring this cycle.
- wb_addr  out  AW  writeback target this cycle.

Behaviour:
- Reset (rst_n low, async): all registers := 0; delay-line valid bits := 0; delay-line addresses := 0.
  - Outputs: abus=bbus=0, hazard=0, wb_en=0, wb_addr=0.
  - In-flight writes are discarded. The first LAT cycles of dbus after reset release are ignored.
- Reads: abus = reg[rs], bbus = reg[rt], purely combinational. Register 0 always reads 0.
- Issue timing: an op issued in cycle N (rd, wen sampled at the rising edge ending N) enters delay-line stage 1.
  - Each edge shifts the line by one stage.
  - In cycle N+LAT, stage LAT drives wb_en/wb_addr.
  - At the edge ending N+LAT, dbus is written to reg[wb_addr] if wb_en=1.
- wb_en = valid bit of stage LAT; wb_addr = address of stage LAT. Both are registered outputs.
- Writes with wb_addr=0 are dropped; the register stays 0. wb_en still reflects the pipeline for visibility.
- Same-cycle read and writeback to one address: without the bypass, the read returns the old value and the new value is visible next cycle.
- hazard = OR over stages 1..LAT of (valid_k && addr_k != 0 && (addr_k == rs || addr_k == rt)).
  - With BYPASS_EN, stage LAT is excluded from this OR.
  - hazard is combinational and advisory: the block never stalls, and the issuer must hold or insert bubbles.
- Bubbles: wen=0 shifts an invalid entry; rd is don't-care.
- Back-to-back issue every cycle is supported; LAT writes can be in flight.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: write-through bypass.
  - If wb_en && wb_addr != 0 && wb_addr == rs, then abus = dbus (likewise bbus for rt).
  - A read in the writeback cycle returns the new value, and stage LAT does not raise hazard.
- Undefined: no bypass mux; same-cycle read returns the old value; stage LAT contributes to hazard.

Test Plan:
- Reset: drive rst_n=0 mid-stream with 2 writes in flight, release, then read r1..r3 -> all 0, wb_en=0 for LAT cycles, no spurious write.
- Basic write/read: issue rd=3, wen=1; model returns dbus=0xDEADBEEF 2 cycles later; read rs=3 at N+3 -> abus=0xDEADBEEF, wb_en=1 and wb_addr=3 during N+2 only.
- r0 protection: issue rd=0, wen=1 with dbus=0x12345678 -> reading rs=0 gives 0 always; hazard never asserted for rs=0.
- Hazard window: issue rd=7 at N, read rs=7 at N+1 -> hazard=1; at N+2 -> hazard=1 without bypass, 0 with bypass; at N+3 -> 0.
- Bypass: with REGFILE_WB_BYPASS_EN, rt=5 during the writeback of 0x0000_00A5 to r5 -> bbus=0x0000_00A5 same cycle; without the macro, bbus=old value 0.
- Back-to-back: issue rd=1,2,3,4 on consecutive cycles with dbus=0x11,0x22,0x33,0x44 -> wb_addr sequence 1,2,3,4 on consecutive cycles; final reads match; a bubble (wen=0) inserted mid-stream produces one wb_en=0 cycle.

Source files
------------

// File: rtl/regfile_wb_stage.sv
// ==========================================================================
// regfile_wb_stage : register file + LAT-deep writeback delay line, Rev 1.0
//   Optional feature macro: REGFILE_WB_BYPASS_EN (write-through bypass)
// ==========================================================================
`default_nettype none

module regfile_wb_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic          wen,
  input  logic [DW-1:0] dbus,
  output logic [DW-1:0] abus,
  output logic [DW-1:0] bbus,
  output logic          hazard,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr
);

  localparam int c_depth = 1 << AW;
`ifdef REGFILE_WB_BYPASS_EN
  localparam int c_hz_last = LAT - 1;
`else
  localparam int c_hz_last = LAT;
`endif

  logic [DW-1:0] r_regs [c_depth];
  logic [LAT:1]  r_vld;
  logic [AW-1:0] r_addr [1:LAT];

  logic          w_wr;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;

  // Destination delay line: stage 1 captures the op issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin : p_pipe
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 1; k <= LAT; k++) begin
        r_addr[k] <= '0;
      end
    end else begin
      r_vld[1]  <= wen;
      r_addr[1] <= rd;
      for (int k = 2; k <= LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
    end
  end

  assign wb_en   = r_vld[LAT];
  assign wb_addr = r_addr[LAT];

  // r0 is never written, so it stays at its reset value of zero.
  assign w_wr = r_vld[LAT] && (r_addr[LAT] != '0);

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[r_addr[LAT]] <= dbus;
    end
  end

  assign w_rd_a = (rs == '0) ? '0 : r_regs[rs];
  assign w_rd_b = (rt == '0) ? '0 : r_regs[rt];

`ifdef REGFILE_WB_BYPASS_EN
  assign abus = (w_wr && (r_addr[LAT] == rs)) ? dbus : w_rd_a;
  assign bbus = (w_wr && (r_addr[LAT] == rt)) ? dbus : w_rd_b;
`else
  assign abus = w_rd_a;
  assign bbus = w_rd_b;
`endif

  // With the bypass, the writeback stage is readable and drops out of the check.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= c_hz_last; k++) begin
      if (r_vld[k] && (r_addr[k] != '0) &&
          ((r_addr[k] == rs) || (r_addr[k] == rt))) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
